// File: rtl/mem_inst_loader_pkg.sv
// -----------------------------------------------------------------------------
// mem_inst_loader_pkg
//   Shared constants and types for the instruction-memory loader:
//   default widths, the HALT opcode that terminates a program image, the
//   loader FSM state encoding and a helper that derives bytes-per-word.
// -----------------------------------------------------------------------------
package mem_inst_loader_pkg;

  // Default word-address width of mem_inst (1024 instruction words).
  localparam int ADDRWIDTH   = 10;
  localparam int NB_DATA_DEF = 32;
  localparam int N_BITS_DEF  = 8;

  // End-of-program marker. It is stored in memory like any other word.
  localparam logic [31:0] HALT_OPCODE = 32'hFFFF_FFFF;

  // Loader FSM states.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RECV  = 3'd1,
    WRITE = 3'd2,
    DONE  = 3'd3,
    OVF   = 3'd4
  } state_e;

  // Number of UART bytes that make up one instruction word.
  function automatic int bytes_per_word(input int nb_data, input int n_bits);
    return nb_data / n_bits;
  endfunction

endpackage : mem_inst_loader_pkg

// File: rtl/mem_inst_loader_if.sv
// -----------------------------------------------------------------------------
// mem_inst_loader_if
//   Bundles the loader's control, UART-receive and memory-side signals.
//   slave  : the loader itself (consumes load_start/rx/pc, drives memory side)
//   master : the surrounding environment (debug unit, fetch stage, memory)
//
//   load_start_i : 1-cycle pulse, begin a new program load
//   rx_done_i    : 1-cycle strobe, rx_data_i carries a valid byte
//   rx_data_i    : received UART byte
//   pc_i         : processor fetch address, routed to memory after handover
//   en_write_o   : mem_inst write strobe
//   en_read_o    : mem_inst read enable
//   mem_addr_o   : mem_inst address
//   inst_load_o  : mem_inst write data
//   loading_o    : load in progress
//   proc_enable_o: program loaded, processor may fetch
//   n_words_o    : words written by the last load, HALT included
//   overflow_o   : sticky, memory filled without a HALT word
// -----------------------------------------------------------------------------
interface mem_inst_loader_if
  import mem_inst_loader_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int N_BITS  = N_BITS_DEF,
  parameter int NB_ADDR = ADDRWIDTH
);

  logic                 load_start_i;
  logic                 rx_done_i;
  logic [N_BITS-1:0]    rx_data_i;
  logic [NB_ADDR-1:0]   pc_i;
  logic                 en_write_o;
  logic                 en_read_o;
  logic [NB_ADDR-1:0]   mem_addr_o;
  logic [NB_DATA-1:0]   inst_load_o;
  logic                 loading_o;
  logic                 proc_enable_o;
  logic [NB_ADDR:0]     n_words_o;
  logic                 overflow_o;

  modport slave (
    input  load_start_i, rx_done_i, rx_data_i, pc_i,
    output en_write_o, en_read_o, mem_addr_o, inst_load_o,
           loading_o, proc_enable_o, n_words_o, overflow_o
  );

  modport master (
    output load_start_i, rx_done_i, rx_data_i, pc_i,
    input  en_write_o, en_read_o, mem_addr_o, inst_load_o,
           loading_o, proc_enable_o, n_words_o, overflow_o
  );

endinterface : mem_inst_loader_if

// File: rtl/mem_inst_loader_byte_assembler.sv
// -----------------------------------------------------------------------------
// mem_inst_loader_byte_assembler
//   Shifts UART bytes MSB-first into an instruction word and flags the strobe
//   that completes it.
//
//   clock_i, reset_i : clock, asynchronous active-low reset
//   clear_i          : drop any partial word and restart at byte 0
//   enable_i         : bytes are accepted only while high
//   rx_done_i        : byte strobe
//   rx_data_i        : byte value
//   word_o           : word including the byte currently on rx_data_i
//   word_valid_o     : combinational, high on the strobe carrying the last
//                      byte of a word (word_o is then the complete word)
// -----------------------------------------------------------------------------
module mem_inst_loader_byte_assembler
  import mem_inst_loader_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int N_BITS  = N_BITS_DEF
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               clear_i,
  input  logic               enable_i,
  input  logic               rx_done_i,
  input  logic [N_BITS-1:0]  rx_data_i,
  output logic [NB_DATA-1:0] word_o,
  output logic               word_valid_o
);

  localparam int NB_BYTES = bytes_per_word(NB_DATA, N_BITS);
  localparam int NB_CNT   = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;
  localparam logic [NB_CNT-1:0] LAST_BYTE = NB_CNT'(NB_BYTES - 1);

  logic [NB_CNT-1:0]  cnt_q, cnt_d;
  logic [NB_DATA-1:0] word_q, word_d;
  logic [NB_DATA-1:0] word_shift;
  logic               take;

  // A clear on the same cycle as a strobe wins: the byte is dropped.
  assign take         = enable_i & rx_done_i & ~clear_i;
  assign word_shift   = {word_q[NB_DATA-N_BITS-1:0], rx_data_i};
  assign word_o       = word_shift;
  assign word_valid_o = take && (cnt_q == LAST_BYTE);

  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    cnt_d  = cnt_q;
    word_d = word_q;
    if (clear_i) begin
      cnt_d  = '0;
      word_d = '0;
    end else if (take) begin
      word_d = word_shift;
      cnt_d  = (cnt_q == LAST_BYTE) ? '0 : cnt_q + NB_CNT'(1);
    end
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_d;
    end
  end

endmodule : mem_inst_loader_byte_assembler

// File: rtl/mem_inst_loader.sv
// -----------------------------------------------------------------------------
// mem_inst_loader
//   Loads a program into mem_inst from the debug-unit UART, one 32-bit word per
//   four bytes, at consecutive word addresses starting from 0. A HALT word ends
//   the load; the memory address port is then handed to the processor PC and
//   the processor is released. Filling the whole memory without a HALT word
//   parks the loader in an overflow state with the processor held.
//
//   clock_i : system clock
//   reset_i : asynchronous active-low reset
//   bus     : mem_inst_loader_if.slave (control, UART bytes, memory port)
// -----------------------------------------------------------------------------
module mem_inst_loader
  import mem_inst_loader_pkg::*;
#(
  parameter int                 NB_DATA   = NB_DATA_DEF,
  parameter int                 N_BITS    = N_BITS_DEF,
  parameter int                 NB_ADDR   = ADDRWIDTH,
  parameter logic [NB_DATA-1:0] HALT_WORD = NB_DATA'(HALT_OPCODE)
) (
  input  logic             clock_i,
  input  logic             reset_i,
  mem_inst_loader_if.slave bus
);

  state_e             state_q;
  logic [NB_ADDR-1:0] addr_q;
  logic [NB_ADDR:0]   n_words_q;
  logic [NB_DATA-1:0] inst_q;
  logic               en_write_q;
  logic               en_read_q;
  logic               loading_q;
  logic               proc_en_q;
  logic               ovf_q;

  logic [NB_DATA-1:0] asm_word;
  logic               asm_valid;
  logic               asm_enable;

  // Bytes are taken in WRITE too, so a byte landing on the write cycle becomes
  // byte 0 of the next word instead of being lost.
  assign asm_enable = (state_q == RECV) || (state_q == WRITE);

  mem_inst_loader_byte_assembler #(
    .NB_DATA (NB_DATA),
    .N_BITS  (N_BITS)
  ) u_byte_assembler (
    .clock_i      (clock_i),
    .reset_i      (reset_i),
    .clear_i      (bus.load_start_i),
    .enable_i     (asm_enable),
    .rx_done_i    (bus.rx_done_i),
    .rx_data_i    (bus.rx_data_i),
    .word_o       (asm_word),
    .word_valid_o (asm_valid)
  );

  // Loader FSM with registered outputs. Every output except mem_addr_o is a
  // flop updated on the transition into the state it belongs to, so the
  // write strobe lands exactly one cycle after the completing byte strobe.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      n_words_q  <= '0;
      inst_q     <= '0;
      en_write_q <= 1'b0;
      en_read_q  <= 1'b0;
      loading_q  <= 1'b0;
      proc_en_q  <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      // NOTE: state lives in flops, so only non-blocking assignments here;
      // later assignments in this block override this default.
      en_write_q <= 1'b0;

      if (bus.load_start_i) begin
        // A start in any state begins a clean load. In WRITE the current
        // strobe has already been issued, so the write still completes.
        state_q   <= RECV;
        addr_q    <= '0;
        n_words_q <= '0;
        ovf_q     <= 1'b0;
        loading_q <= 1'b1;
        proc_en_q <= 1'b0;
        en_read_q <= 1'b0;
      end else begin
        unique case (state_q)
          RECV: begin
            if (asm_valid) begin
              state_q    <= WRITE;
              en_write_q <= 1'b1;
              inst_q     <= asm_word;
              n_words_q  <= n_words_q + (NB_ADDR+1)'(1);
            end
          end

          WRITE: begin
            if (inst_q == HALT_WORD) begin
              state_q   <= DONE;
              loading_q <= 1'b0;
              proc_en_q <= 1'b1;
              en_read_q <= 1'b1;
            end else if (addr_q == {NB_ADDR{1'b1}}) begin
              // Last address written and still no HALT: stop writing.
              state_q   <= OVF;
              loading_q <= 1'b0;
              ovf_q     <= 1'b1;
            end else begin
              addr_q  <= addr_q + NB_ADDR'(1);
              state_q <= RECV;
            end
          end

          default: begin
            // IDLE, DONE and OVF only leave on load_start_i.
          end
        endcase
      end
    end
  end

  // After handover the processor PC drives the memory address directly.
  assign bus.mem_addr_o    = (state_q == DONE) ? bus.pc_i : addr_q;
  assign bus.en_write_o    = en_write_q;
  assign bus.en_read_o     = en_read_q;
  assign bus.inst_load_o   = inst_q;
  assign bus.loading_o     = loading_q;
  assign bus.proc_enable_o = proc_en_q;
  assign bus.n_words_o     = n_words_q;
  assign bus.overflow_o    = ovf_q;

endmodule : mem_inst_loader

// File: doc/mem_inst_loader.md
Name: mem_inst_loader

Overview:
Sequences the instruction-memory load phase. It assembles UART bytes from the debug unit into 32-bit instructions and writes them to consecutive word addresses of mem_inst. It detects the HALT word that ends a program, then hands the memory address port over to the processor PC and releases the processor to run. It sits between the debug-unit UART receiver, mem_inst and the pipeline fetch stage.

Parameters:
NB_DATA, 32, instruction width in bits.
N_BITS, 8, UART byte width; NB_DATA/N_BITS bytes make one word (4 by default).
NB_ADDR, `ADDRWIDTH, word-address width of mem_inst.
HALT_WORD, 32'hFFFFFFFF, end-of-program instruction; it is written to memory, and the load then ends.

Ports:
clock_i  in  1  single system clock (processor clock domain).
reset_i  in  1  asynchronous, active-low reset.
load_start_i  in  1  1-cycle pulse; begin a new program load.
rx_done_i  in  1  1-cycle strobe; rx_data_i holds a valid byte.
rx_data_i  in  N_BITS  received byte.
pc_i  in  NB_ADDR  processor fetch address, used after handover.
en_write_o  out  1  write strobe to mem_inst.
en_read_o  out  1  read enable to mem_inst.
mem_addr_o  out  NB_ADDR  address to mem_inst.addr_i.
inst_load_o  out  NB_DATA  write data to mem_inst.data_i.
loading_o  out  1  high while a load is in progress.
proc_enable_o  out  1  high once the program is loaded; processor may fetch.
n_words_o  out  NB_ADDR+1  words written in the last load, HALT included.
overflow_o  out  1  sticky; memory filled without a HALT word.

Behaviour:
- Reset (reset_i=0, async) drives state to IDLE and every output to 0. The byte counter, word shift register and address counter also clear to 0.
- States: IDLE, RECV, WRITE, DONE, OVF.
- IDLE:
  - en_read_o=0, proc_enable_o=0.
  - load_start_i -> RECV. Address counter, byte counter and n_words_o clear; overflow_o clears.
  - rx_done_i is ignored.
- RECV: loading_o=1.
  - Each rx_done_i shifts the byte in MSB-first: word <= {word[NB_DATA-N_BITS-1:0], rx_data_i}. The byte counter then increments.
  - On the strobe that carries the 4th byte, go to WRITE the next cycle. The byte counter wraps to 0.
- WRITE: exactly 1 cycle.
  - en_write_o=1, mem_addr_o=address counter, inst_load_o=assembled word.
  - n_words_o increments by 1.
  - If word==HALT_WORD -> DONE.
  - Else if address counter == 2^NB_ADDR-1 -> OVF.
  - Else the address counter increments and the FSM returns to RECV.
- A rx_done_i arriving during WRITE is accepted: it is shifted in as byte 0 of the next word, so no byte is lost.
- Latency: the write strobe occurs 1 cycle after the 4th byte strobe.
- DONE: loading_o=0, proc_enable_o=1, en_read_o=1, mem_addr_o=pc_i (combinational mux), en_write_o=0.
  - load_start_i -> RECV, with the counters cleared as in IDLE.
  - In the cycle load_start_i is seen, proc_enable_o drops in the next cycle.
- OVF: overflow_o=1, proc_enable_o=0, loading_o=0, no writes. load_start_i -> RECV; overflow_o clears.
- load_start_i during RECV or WRITE restarts the load:
  - Counters clear and the partial word is discarded.
  - A WRITE already in progress completes its single strobe first.
- Outside the DONE state, mem_addr_o = address counter, and inst_load_o holds the last assembled word.
- Simultaneous load_start_i and rx_done_i in IDLE or DONE: the byte is dropped; the load begins cleanly.
- Reset mid-load: the memory contents are not cleared; only the FSM and outputs reset.

Decomposition:
- Shared package/header (parameters.vh):
  - ADDRWIDTH and the HALT opcode constant.
  - State encodings as `define localparams: IDLE=3'd0, RECV=3'd1, WRITE=3'd2, DONE=3'd3, OVF=3'd4.
- One natural sub-module, byte_assembler: the shift register plus byte counter, with word_valid pulse output.
- FSM, address counter and address mux stay in mem_inst_loader.

Test Plan:
- Reset then pulse load_start_i; send bytes 8'h20,8'h01,8'h00,8'h05 -> one en_write_o at address 0 with inst_load_o=32'h20010005, 1 cycle after the 4th strobe; n_words_o=1.
- Load 3 words followed by 8'hFF x4 -> writes at addresses 0,1,2,3 with the last word 32'hFFFFFFFF. The FSM then reaches DONE: proc_enable_o=1, n_words_o=4, and mem_addr_o follows pc_i (drive pc_i=5 -> mem_addr_o=5).
- Send 2^NB_ADDR non-HALT words -> the last write lands at address 2^NB_ADDR-1, then overflow_o=1, proc_enable_o=0, and no further en_write_o.
- Send 2 bytes, pulse load_start_i, then send 8'hAA,8'hBB,8'hCC,8'hDD -> the single write is at address 0 with data 32'hAABBCCDD.
- Send back-to-back strobes with the next byte arriving in the WRITE cycle -> the second word is assembled correctly and written at address 1.
- Assert reset_i=0 mid-RECV, asynchronously between clock edges -> all outputs read 0 immediately and the state is IDLE; after release, a new load starts at address 0.
